// File: rtl/program_counter_if.sv
// Fetch-path command/stack bus between the decoder, the program counter and
// the instruction stack.
//   slave  : the program counter (consumes commands and stack read data,
//            drives the PC, stack strobes and status)
//   master : whatever drives the commands (decoder or testbench)
interface program_counter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_halt;
    logic                  i_stall;
    logic                  i_jump;
    logic                  i_branch;
    logic                  i_flag;
    logic                  i_call;
    logic                  i_rtrn;
    logic [DATA_WIDTH-1:0] i_target;
    logic [DATA_WIDTH-1:0] i_stack;
    logic [DATA_WIDTH-1:0] o_PC;
    logic                  o_call;
    logic                  o_rtrn;
    logic                  o_busy;
    logic                  o_halted;
    logic                  o_ovf;
    logic                  o_unf;

    modport slave (
        input  i_halt, i_stall, i_jump, i_branch, i_flag, i_call, i_rtrn,
        input  i_target, i_stack,
        output o_PC, o_call, o_rtrn, o_busy, o_halted, o_ovf, o_unf
    );

    modport master (
        output i_halt, i_stall, i_jump, i_branch, i_flag, i_call, i_rtrn,
        output i_target, i_stack,
        input  o_PC, o_call, o_rtrn, o_busy, o_halted, o_ovf, o_unf
    );
endinterface

// File: rtl/program_counter.sv
// Program counter / next-address sequencer for the FRANK6000 fetch path.
// Selects the next PC (increment, jump, branch, call, return), drives the
// instruction stack push/pop strobes and tracks the stack depth so that
// overflow/underflow halt the core.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : commands, branch target, stack read data in;
//                  PC, stack strobes, busy/halted/ovf/unf status out
module program_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    program_counter_if.slave bus
);
    typedef enum logic [1:0] {RUN, RET_WAIT, HALT} state_t;

    // Depth counter is one bit wider than the stack pointer so "full" is
    // distinguishable from "empty".
    localparam logic [ADDR_WIDTH:0] DEPTH_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH:0]   depth_q, depth_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic                  call_s, rtrn_s;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        call_s  = 1'b0;
        rtrn_s  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.i_halt) begin
                    state_d = HALT;
                end else if (bus.i_stall) begin
                    // hold PC, no stack traffic
                end else if (bus.i_rtrn) begin
                    if (depth_q == '0) begin
                        unf_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        rtrn_s  = 1'b1;
                        depth_d = depth_q - (ADDR_WIDTH+1)'(1);
                        state_d = RET_WAIT;
                    end
                end else if (bus.i_call) begin
                    if (depth_q == DEPTH_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        // stack captures o_PC+1 on this same edge
                        call_s  = 1'b1;
                        depth_d = depth_q + (ADDR_WIDTH+1)'(1);
                        pc_d    = bus.i_target;
                    end
                end else if (bus.i_jump) begin
                    pc_d = bus.i_target;
                end else if (bus.i_branch && bus.i_flag) begin
                    pc_d = bus.i_target;
                end else begin
                    pc_d = pc_q + DATA_WIDTH'(1);
                end
            end
            // Stack read data is registered, so it is valid only now;
            // every command input is ignored for this one cycle.
            RET_WAIT: begin
                pc_d    = bus.i_stack;
                state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
        busy_d   = (state_d == RET_WAIT);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= RUN;
            pc_q     <= '0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign bus.o_PC     = pc_q;
    assign bus.o_call   = call_s;
    assign bus.o_rtrn   = rtrn_s;
    assign bus.o_busy   = busy_q;
    assign bus.o_halted = halted_q;
    assign bus.o_ovf    = ovf_q;
    assign bus.o_unf    = unf_q;
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter. A behavioural instruction stack
// model sits downstream; expected PC values go into a queue as commands are
// driven and are popped and compared after the accepting edge.
module tb_program_counter;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_pc;

    program_counter_if #(.DATA_WIDTH(8)) bus();

    program_counter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // Downstream stack: push o_PC+1 on o_call, registered read of top on o_rtrn.
    logic [7:0] stk [0:15];
    logic [4:0] sp;
    logic [7:0] stk_rd;
    always @(posedge i_clk) begin
        if (i_rst) begin
            sp     <= '0;
            stk_rd <= '0;
        end else if (bus.o_call) begin
            stk[sp[3:0]] <= bus.o_PC + 8'd1;
            sp           <= sp + 5'd1;
        end else if (bus.o_rtrn) begin
            stk_rd <= stk[4'(sp - 5'd1)];
            sp     <= sp - 5'd1;
        end
    end
    assign bus.i_stack = stk_rd;

    task automatic idle();
        bus.i_halt = 0; bus.i_stall = 0; bus.i_jump = 0; bus.i_branch = 0;
        bus.i_flag = 0; bus.i_call = 0; bus.i_rtrn = 0; bus.i_target = '0;
    endtask

    task automatic clk_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1;
        clk_edge();
        i_rst = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1;
        clk_edge();
        clk_edge();
        i_rst = 0;
        #1;
        checks++;
        if (bus.o_PC !== 8'h00) begin
            errors++; $display("FAIL reset_pc got=%h exp=00", bus.o_PC);
        end
        checks++;
        if ({bus.o_call, bus.o_rtrn, bus.o_busy, bus.o_halted, bus.o_ovf, bus.o_unf} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {bus.o_call, bus.o_rtrn, bus.o_busy, bus.o_halted, bus.o_ovf, bus.o_unf});
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(8'(i + 1));
            clk_edge();
            exp_pc = exp_q.pop_front();
            checks++;
            if (bus.o_PC !== exp_pc) begin
                errors++; $display("FAIL count_pc cyc=%0d got=%h exp=%h", i, bus.o_PC, exp_pc);
            end
            checks++;
            if ((bus.o_call | bus.o_rtrn) !== 1'b0) begin
                errors++; $display("FAIL count_strobe cyc=%0d got=%b%b exp=00", i, bus.o_call, bus.o_rtrn);
            end
        end
    endtask

    task automatic test_call_return();
        do_reset();
        repeat (16) clk_edge();
        checks++;
        if (bus.o_PC !== 8'h10) begin
            errors++; $display("FAIL cr_start got=%h exp=10", bus.o_PC);
        end
        bus.i_call = 1; bus.i_target = 8'h40;
        #1;
        checks++;
        if ({bus.o_call, bus.o_rtrn} !== 2'b10) begin
            errors++; $display("FAIL cr_call_strobe got=%b%b exp=10", bus.o_call, bus.o_rtrn);
        end
        exp_q.push_back(8'h40);
        clk_edge();
        idle();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.o_PC !== exp_pc) begin
            errors++; $display("FAIL cr_call_pc got=%h exp=%h", bus.o_PC, exp_pc);
        end
        checks++;
        if (sp !== 5'd1 || stk[0] !== 8'h11) begin
            errors++; $display("FAIL cr_pushed got=sp%0d/%h exp=sp1/11", sp, stk[0]);
        end
        bus.i_rtrn = 1;
        #1;
        checks++;
        if ({bus.o_call, bus.o_rtrn} !== 2'b01) begin
            errors++; $display("FAIL cr_rtrn_strobe got=%b%b exp=01", bus.o_call, bus.o_rtrn);
        end
        clk_edge();
        // commands during RET_WAIT must be ignored
        idle();
        bus.i_halt = 1; bus.i_jump = 1; bus.i_rtrn = 1; bus.i_target = 8'hEE;
        #1;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_rtrn !== 1'b0 || bus.o_PC !== 8'h40) begin
            errors++;
            $display("FAIL cr_wait got=busy%b rtrn%b pc%h exp=busy1 rtrn0 pc40", bus.o_busy, bus.o_rtrn, bus.o_PC);
        end
        exp_q.push_back(8'h11);
        clk_edge();
        idle();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.o_PC !== exp_pc || bus.o_busy !== 1'b0 || bus.o_halted !== 1'b0) begin
            errors++;
            $display("FAIL cr_ret_pc got=%h busy%b halt%b exp=%h busy0 halt0", bus.o_PC, bus.o_busy, bus.o_halted, exp_pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (5) clk_edge();
        bus.i_branch = 1; bus.i_flag = 0; bus.i_target = 8'h80;
        exp_q.push_back(8'h06);
        clk_edge();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.o_PC !== exp_pc) begin
            errors++; $display("FAIL br_not_taken got=%h exp=%h", bus.o_PC, exp_pc);
        end
        bus.i_flag = 1;
        exp_q.push_back(8'h80);
        clk_edge();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.o_PC !== exp_pc) begin
            errors++; $display("FAIL br_taken got=%h exp=%h", bus.o_PC, exp_pc);
        end
        idle();
        bus.i_jump = 1; bus.i_call = 1; bus.i_target = 8'h20;
        #1;
        checks++;
        if (bus.o_call !== 1'b1) begin
            errors++; $display("FAIL jmp_call_strobe got=%b exp=1", bus.o_call);
        end
        exp_q.push_back(8'h20);
        clk_edge();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.o_PC !== exp_pc || sp !== 5'd1 || stk[0] !== 8'h81) begin
            errors++; $display("FAIL jmp_call_pc got=%h/%h exp=%h/81", bus.o_PC, stk[0], exp_pc);
        end
        idle();
        bus.i_stall = 1; bus.i_call = 1; bus.i_target = 8'h33;
        #1;
        checks++;
        if ({bus.o_call, bus.o_rtrn} !== 2'b00) begin
            errors++; $display("FAIL stall_strobe got=%b%b exp=00", bus.o_call, bus.o_rtrn);
        end
        exp_q.push_back(8'h20);
        clk_edge();
        idle();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.o_PC !== exp_pc) begin
            errors++; $display("FAIL stall_pc got=%h exp=%h", bus.o_PC, exp_pc);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus.i_call = 1; bus.i_target = 8'(8'h40 + k);
            #1;
            checks++;
            if (bus.o_call !== 1'b1) begin
                errors++; $display("FAIL ovf_call_strobe k=%0d got=%b exp=1", k, bus.o_call);
            end
            exp_q.push_back(8'(8'h40 + k));
            clk_edge();
            exp_pc = exp_q.pop_front();
            checks++;
            if (bus.o_PC !== exp_pc || bus.o_halted !== 1'b0) begin
                errors++; $display("FAIL ovf_call_pc k=%0d got=%h exp=%h", k, bus.o_PC, exp_pc);
            end
        end
        bus.i_target = 8'h99;
        #1;
        checks++;
        if (bus.o_call !== 1'b0) begin
            errors++; $display("FAIL ovf_17_strobe got=%b exp=0", bus.o_call);
        end
        clk_edge();
        checks++;
        if ({bus.o_ovf, bus.o_unf, bus.o_halted} !== 3'b101 || bus.o_PC !== 8'h4F) begin
            errors++;
            $display("FAIL ovf_halt got=ovf%b unf%b halt%b pc%h exp=ovf1 unf0 halt1 pc4f",
                     bus.o_ovf, bus.o_unf, bus.o_halted, bus.o_PC);
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            bus.i_jump = 1; bus.i_rtrn = k[0]; bus.i_call = ~k[0]; bus.i_target = 8'h12;
            #1;
            checks++;
            if ({bus.o_call, bus.o_rtrn} !== 2'b00) begin
                errors++; $display("FAIL halt_strobe k=%0d got=%b%b exp=00", k, bus.o_call, bus.o_rtrn);
            end
            clk_edge();
            checks++;
            if (bus.o_PC !== 8'h4F || bus.o_halted !== 1'b1) begin
                errors++; $display("FAIL halt_frozen k=%0d got=%h exp=4f", k, bus.o_PC);
            end
        end
        do_reset();
        checks++;
        if ({bus.o_ovf, bus.o_halted} !== 2'b00 || bus.o_PC !== 8'h00) begin
            errors++; $display("FAIL ovf_reset got=ovf%b halt%b pc%h exp=0 0 00", bus.o_ovf, bus.o_halted, bus.o_PC);
        end
    endtask

    task automatic test_underflow_halt();
        do_reset();
        bus.i_rtrn = 1;
        #1;
        checks++;
        if (bus.o_rtrn !== 1'b0) begin
            errors++; $display("FAIL unf_strobe got=%b exp=0", bus.o_rtrn);
        end
        clk_edge();
        idle();
        checks++;
        if ({bus.o_ovf, bus.o_unf, bus.o_halted} !== 3'b011 || bus.o_PC !== 8'h00) begin
            errors++;
            $display("FAIL unf_halt got=ovf%b unf%b halt%b pc%h exp=0 1 1 00", bus.o_ovf, bus.o_unf, bus.o_halted, bus.o_PC);
        end
        do_reset();
        clk_edge();
        clk_edge();
        bus.i_halt = 1; bus.i_jump = 1; bus.i_target = 8'h77;
        clk_edge();
        idle();
        clk_edge();
        checks++;
        if (bus.o_PC !== 8'h02 || bus.o_halted !== 1'b1 || bus.o_ovf !== 1'b0 || bus.o_unf !== 1'b0) begin
            errors++; $display("FAIL hlt_cmd got=pc%h halt%b exp=pc02 halt1", bus.o_PC, bus.o_halted);
        end
    endtask

    task automatic test_ret_reset();
        do_reset();
        bus.i_call = 1; bus.i_target = 8'h30;
        clk_edge();
        idle();
        bus.i_rtrn = 1;
        clk_edge();
        idle();
        i_rst = 1;
        clk_edge();
        i_rst = 0;
        checks++;
        if (bus.o_PC !== 8'h00 || bus.o_busy !== 1'b0 || bus.o_halted !== 1'b0) begin
            errors++; $display("FAIL rr_reset got=pc%h busy%b exp=pc00 busy0", bus.o_PC, bus.o_busy);
        end
        bus.i_call = 1; bus.i_target = 8'h50;
        #1;
        checks++;
        if (bus.o_call !== 1'b1) begin
            errors++; $display("FAIL rr_call_strobe got=%b exp=1", bus.o_call);
        end
        clk_edge();
        idle();
        checks++;
        if (sp !== 5'd1 || stk[0] !== 8'h01 || bus.o_PC !== 8'h50) begin
            errors++; $display("FAIL rr_push got=sp%0d/%h pc%h exp=sp1/01 pc50", sp, stk[0], bus.o_PC);
        end
        bus.i_rtrn = 1;
        exp_q.push_back(8'h01);
        clk_edge();
        idle();
        clk_edge();
        exp_pc = exp_q.pop_front();
        checks++;
        if (bus.o_PC !== exp_pc) begin
            errors++; $display("FAIL rr_ret_pc got=%h exp=%h", bus.o_PC, exp_pc);
        end
        // depth is back to zero, so one more return must underflow
        bus.i_rtrn = 1;
        clk_edge();
        idle();
        checks++;
        if (bus.o_unf !== 1'b1 || bus.o_halted !== 1'b1) begin
            errors++; $display("FAIL rr_depth got=unf%b halt%b exp=unf1 halt1", bus.o_unf, bus.o_halted);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_count();
        test_call_return();
        test_branch();
        test_overflow();
        test_underflow_halt();
        test_ret_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_counter.md
# program_counter

Program counter and next-address sequencer for the FRANK6000 fetch path. It holds the current instruction address, selects the next one (increment, jump, conditional branch, call, return), and drives the instruction stack directly downstream: it supplies the PC that is pushed on a call and consumes the stack's registered read data on a return. It also mirrors the stack depth so that overflow and underflow halt the core instead of corrupting the return chain.

## Interface
- DATA_WIDTH, 8, width of the instruction address and of the stack entries
- ADDR_WIDTH, 4, instruction stack address width; stack depth is 2^ADDR_WIDTH
- i_clk  input  1  single clock; all state updates on the rising edge
- i_rst  input  1  reset, synchronous and active-high
- i_halt  input  1  request permanent halt (HLT instruction)
- i_stall  input  1  hold the PC this cycle; no stack operation
- i_jump  input  1  unconditional jump to i_target
- i_branch  input  1  conditional branch to i_target when i_flag=1
- i_flag  input  1  branch condition from the ALU flags
- i_call  input  1  call: push the return address, jump to i_target
- i_rtrn  input  1  return: pop the return address
- i_target  input  DATA_WIDTH  jump, branch or call destination
- i_stack  input  DATA_WIDTH  instruction stack read data (registered, valid one cycle after the pop)
- o_PC  output  DATA_WIDTH  current instruction address; feeds program ROM and stack i_PC
- o_call  output  1  stack push strobe; the stack stores o_PC+1
- o_rtrn  output  1  stack pop strobe
- o_busy  output  1  return in progress; upstream must hold its command
- o_halted  output  1  core is halted
- o_ovf  output  1  sticky flag: call attempted with the stack full
- o_unf  output  1  sticky flag: return attempted with the stack empty

## Operation
- States: RUN, RET_WAIT, HALT. Internal depth counter is ADDR_WIDTH+1 bits wide, range 0..2^ADDR_WIDTH.
- Reset (synchronous, from any state): o_PC=0, state=RUN, depth=0, o_ovf=o_unf=0. All outputs are then 0.
- In RUN, the following priority applies each cycle. The first matching row wins.
  1. i_halt: go to HALT; PC held.
  2. i_stall: PC held; no strobes.
  3. i_rtrn:
     - If depth=0: set o_unf and go to HALT; no strobe.
     - Otherwise: o_rtrn=1, depth-1, go to RET_WAIT; PC held.
  4. i_call:
     - If depth=2^ADDR_WIDTH: set o_ovf and go to HALT; no strobe.
     - Otherwise: o_call=1, depth+1, PC<=i_target.
  5. i_jump: PC<=i_target.
  6. i_branch and i_flag: PC<=i_target.
  7. Otherwise (including i_branch with i_flag=0): PC<=PC+1, modulo 2^DATA_WIDTH. 0xFF wraps to 0x00.
- RET_WAIT: lasts exactly one cycle. PC<=i_stack, then go to RUN. All command inputs are ignored, including i_halt and i_stall. o_busy=1.
- HALT: PC frozen, strobes 0, o_halted=1. The only exit is i_rst.
- Strobe outputs:
  - o_call and o_rtrn are combinational from the inputs and state, so the stack sees them in the same cycle.
  - They are never both high.
  - They are never high outside RUN.
- Depth changes only together with a strobe. It therefore always equals the stack's own pointer.

## Timing
- Increment, jump, branch and call: 1 cycle. The new o_PC is visible after the edge that accepts the command.
- Call: at the accepting edge the stack writes o_PC+1 at its current pointer.
- Return: 2 cycles.
  - Edge 1: the stack performs its registered read of entry pointer-1 and decrements its pointer.
  - Edge 2: o_PC <= i_stack.
  - o_PC shows the pre-return value for both cycles.
- o_halted, o_ovf and o_unf rise on the edge that enters HALT.
- Reset asserted during RET_WAIT: the next edge gives PC=0 and RUN. The pending return is discarded.

## Test plan
- Reset, then 300 idle cycles -> o_PC counts 0..255 and wraps to 0 at cycle 256; no strobes.
- At PC=0x10, i_call with i_target=0x40 -> o_call high that cycle, o_PC=0x40 next. Later i_rtrn -> o_rtrn for 1 cycle, o_busy for 1 cycle, then o_PC=0x11.
- i_branch with i_flag=0 at PC=0x05 -> 0x06. i_branch with i_flag=1 and i_target=0x80 -> 0x80. i_jump together with i_call -> the call wins and o_call=1.
- 16 nested calls (ADDR_WIDTH=4) succeed. The 17th call -> o_ovf=1, o_halted=1, no o_call, PC frozen until reset.
- i_rtrn right after reset -> o_unf=1 and halt, no o_rtrn. i_stall high together with i_call -> PC held, no strobe.
- i_rtrn, then i_rst during RET_WAIT -> o_PC=0, RUN, depth 0. A following call pushes 0x01.
